wb_stage: RTL and testbench

Parametrised write-back stage for the 5-stage MIPS pipeline, sitting between step_mm and the register file. It registers the MM result and decides register-file write enables from the memory access type. It extracts and sign/zero-extends byte, halfword and word loads, and stalls upstream while a load's read data is still outstanding. It also drives a registered forwarding port back to step_id/step_ex.

---
 rtl/wb_stage.sv | 206 ++++++++++++++++++++
 tb/tb_wb_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage
// Write-back stage of the 5-stage MIPS pipeline, between step_mm and the
// register file. Registers the MM result, decides the register-file write
// strobe from the memory access type, extracts and extends byte/half/word
// loads, and holds off upstream while load data is still outstanding. The
// registered write port also serves as the forwarding port for step_id/step_ex.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   flush             drop the accepted and any pending instruction
//   in_valid/in_ready handshake with MM (in_ready is combinational, = IDLE)
//   mem_access_type   NONE / R2R / M2R / R2M
//   data_i            ALU result for R2R writes
//   reg_addr_i        destination register
//   load_size         0 byte, 1 half, 2 word, 3 treated as word
//   load_signed       sign-extend byte/half loads
//   addr_lo           low two bits of the load address
//   mem_rdata_valid   mem_rdata carries the load word this cycle
//   mem_rdata         raw aligned memory word
//   reg_write_*       registered write strobe / address / data
//   misalign          one-cycle pulse for a misaligned load (no write)
//   busy              waiting for load data
module wb_stage #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter bit          LOAD_EXT    = 1'b1,
  parameter bit          ZERO_REG_WP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mem_access_type,
  input  logic [31:0]           data_i,
  input  logic [REG_ADDR_W-1:0] reg_addr_i,
  input  logic [1:0]            load_size,
  input  logic                  load_signed,
  input  logic [1:0]            addr_lo,
  input  logic                  mem_rdata_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  reg_write_enable,
  output logic [REG_ADDR_W-1:0] reg_write_addr,
  output logic [31:0]           reg_write_data,
  output logic                  misalign,
  output logic                  busy
);

  localparam logic [1:0] MEM_ACCESS_TYPE_NONE = 2'd0;
  localparam logic [1:0] MEM_ACCESS_TYPE_R2R  = 2'd1;
  localparam logic [1:0] MEM_ACCESS_TYPE_M2R  = 2'd2;
  localparam logic [1:0] MEM_ACCESS_TYPE_R2M  = 2'd3;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                  state, state_next;
  logic [REG_ADDR_W-1:0]   pend_addr, pend_addr_next;
  logic [1:0]              pend_size, pend_size_next;
  logic                    pend_signed, pend_signed_next;
  logic [1:0]              pend_lo, pend_lo_next;

  logic                    we_next, mis_next;
  logic [REG_ADDR_W-1:0]   addr_next;
  logic [31:0]             data_next;

  logic [REG_ADDR_W-1:0]   ld_addr;
  logic [1:0]              ld_size;
  logic                    ld_signed;
  logic [1:0]              ld_lo;
  logic [7:0]              byte_val;
  logic [15:0]             half_val;
  logic [31:0]             ext_data;
  logic                    ld_misalign;

  assign in_ready = (state == IDLE);
  assign busy     = (state == WAIT_MEM);

  // Load descriptor comes from the inputs on a same-cycle hit and from the
  // latched copy while waiting, so one extractor serves both paths.
  always_comb begin
    ld_addr     = reg_addr_i;
    ld_size     = load_size;
    ld_signed   = load_signed;
    ld_lo       = addr_lo;
    if (state == WAIT_MEM) begin
      ld_addr   = pend_addr;
      ld_size   = pend_size;
      ld_signed = pend_signed;
      ld_lo     = pend_lo;
    end

    byte_val = mem_rdata[7:0];
    case (ld_lo)
      2'd1:    byte_val = mem_rdata[15:8];
      2'd2:    byte_val = mem_rdata[23:16];
      2'd3:    byte_val = mem_rdata[31:24];
      default: byte_val = mem_rdata[7:0];
    endcase
    half_val = ld_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    ext_data    = mem_rdata;
    ld_misalign = 1'b0;
    if (LOAD_EXT) begin
      case (ld_size)
        2'd0: ext_data = {{24{ld_signed & byte_val[7]}}, byte_val};
        2'd1: begin
          ext_data    = {{16{ld_signed & half_val[15]}}, half_val};
          ld_misalign = ld_lo[0];
        end
        default: ld_misalign = (ld_lo != 2'd0);
      endcase
    end
  end

  // Next-state and next-output logic. Flush overrides everything; a
  // misaligned load raises misalign instead of writing and leaves the
  // address/data registers holding their previous values.
  always_comb begin
    state_next       = state;
    pend_addr_next   = pend_addr;
    pend_size_next   = pend_size;
    pend_signed_next = pend_signed;
    pend_lo_next     = pend_lo;
    we_next          = 1'b0;
    mis_next         = 1'b0;
    addr_next        = reg_write_addr;
    data_next        = reg_write_data;

    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (mem_access_type)
              MEM_ACCESS_TYPE_R2R: begin
                we_next   = !(ZERO_REG_WP && (reg_addr_i == '0));
                addr_next = reg_addr_i;
                data_next = data_i;
              end
              MEM_ACCESS_TYPE_M2R: begin
                if (mem_rdata_valid) begin
                  if (ld_misalign) begin
                    mis_next = 1'b1;
                  end else begin
                    we_next   = !(ZERO_REG_WP && (ld_addr == '0));
                    addr_next = ld_addr;
                    data_next = ext_data;
                  end
                end else begin
                  pend_addr_next   = reg_addr_i;
                  pend_size_next   = load_size;
                  pend_signed_next = load_signed;
                  pend_lo_next     = addr_lo;
                  state_next       = WAIT_MEM;
                end
              end
              MEM_ACCESS_TYPE_NONE, MEM_ACCESS_TYPE_R2M: begin
                we_next = 1'b0;
              end
              default: we_next = 1'b0;
            endcase
          end
        end
        WAIT_MEM: begin
          if (mem_rdata_valid) begin
            state_next = IDLE;
            if (ld_misalign) begin
              mis_next = 1'b1;
            end else begin
              we_next   = !(ZERO_REG_WP && (ld_addr == '0));
              addr_next = ld_addr;
              data_next = ext_data;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pend_addr        <= '0;
      pend_size        <= 2'd0;
      pend_signed      <= 1'b0;
      pend_lo          <= 2'd0;
      reg_write_enable <= 1'b0;
      reg_write_addr   <= '0;
      reg_write_data   <= 32'd0;
      misalign         <= 1'b0;
    end else begin
      state            <= state_next;
      pend_addr        <= pend_addr_next;
      pend_size        <= pend_size_next;
      pend_signed      <= pend_signed_next;
      pend_lo          <= pend_lo_next;
      reg_write_enable <= we_next;
      reg_write_addr   <= addr_next;
      reg_write_data   <= data_next;
      misalign         <= mis_next;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vectors, expected write strobes queued by
// the stimulus and popped by an independent monitor whenever the DUT raises
// reg_write_enable or misalign.
module tb_wb_stage;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_R2R  = 2'd1;
  localparam logic [1:0] T_M2R  = 2'd2;
  localparam logic [1:0] T_R2M  = 2'd3;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mem_access_type;
  logic [31:0] data_i;
  logic [4:0]  reg_addr_i;
  logic [1:0]  load_size;
  logic        load_signed;
  logic [1:0]  addr_lo;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        reg_write_enable;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic        misalign;
  logic        busy;

  typedef struct {
    logic        mis;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  wb_stage #(.REG_ADDR_W(5), .LOAD_EXT(1'b1), .ZERO_REG_WP(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mem_access_type(mem_access_type), .data_i(data_i), .reg_addr_i(reg_addr_i),
    .load_size(load_size), .load_signed(load_signed), .addr_lo(addr_lo),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .misalign(misalign), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] t, input logic [4:0] ra,
                               input logic [31:0] d, input logic [1:0] sz, input logic sg,
                               input logic [1:0] lo, input logic mv, input logic [31:0] md);
    in_valid        = v;
    mem_access_type = t;
    reg_addr_i      = ra;
    data_i          = d;
    load_size       = sz;
    load_signed     = sg;
    addr_lo         = lo;
    mem_rdata_valid = mv;
    mem_rdata       = md;
  endtask

  task automatic idle();
    applyStimulus(1'b0, T_NONE, 5'd0, 32'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'd0);
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.mis = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expectMisalign();
    exp_t e;
    e.mis = 1'b1; e.addr = 5'd0; e.data = 32'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: any strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reg_write_enable || misalign) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL unexpected_strobe: got en=%0b mis=%0b addr=%0d data=0x%08h expected no strobe",
                 reg_write_enable, misalign, reg_write_addr, reg_write_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("strobe_misalign", {31'd0, misalign}, {31'd0, e.mis});
        checkOutput("strobe_enable", {31'd0, reg_write_enable}, {31'd0, ~e.mis});
        if (!e.mis) begin
          checkOutput("strobe_addr", {27'd0, reg_write_addr}, {27'd0, e.addr});
          checkOutput("strobe_data", reg_write_data, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_enable", {31'd0, reg_write_enable}, 32'd0);
    checkOutput("reset_addr", {27'd0, reg_write_addr}, 32'd0);
    checkOutput("reset_data", reg_write_data, 32'd0);
    checkOutput("reset_misalign", {31'd0, misalign}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // R2R write, then one-cycle strobe
    applyStimulus(1'b1, T_R2R, 5'd5, 32'hDEADBEEF, 2'd2, 1'b0, 2'd0, 1'b0, 32'd0);
    expectWrite(5'd5, 32'hDEADBEEF);
    step();
    idle();
    step();
    checkOutput("r2r_pulse_end", {31'd0, reg_write_enable}, 32'd0);
    checkOutput("r2r_addr_hold", {27'd0, reg_write_addr}, 32'd5);
    checkOutput("r2r_data_hold", reg_write_data, 32'hDEADBEEF);

    // Same-cycle loads back to back: signed byte, unsigned byte, other sizes
    applyStimulus(1'b1, T_M2R, 5'd7, 32'd0, 2'd0, 1'b1, 2'd3, 1'b1, 32'h80123456);
    expectWrite(5'd7, 32'hFFFFFF80);
    step();
    applyStimulus(1'b1, T_M2R, 5'd8, 32'd0, 2'd0, 1'b0, 2'd3, 1'b1, 32'h80123456);
    expectWrite(5'd8, 32'h00000080);
    step();
    applyStimulus(1'b1, T_M2R, 5'd12, 32'd0, 2'd0, 1'b1, 2'd1, 1'b1, 32'h80123456);
    expectWrite(5'd12, 32'h00000034);
    step();
    applyStimulus(1'b1, T_M2R, 5'd13, 32'd0, 2'd1, 1'b1, 2'd0, 1'b1, 32'h1234F00D);
    expectWrite(5'd13, 32'hFFFFF00D);
    step();
    applyStimulus(1'b1, T_M2R, 5'd14, 32'd0, 2'd3, 1'b1, 2'd0, 1'b1, 32'hCAFEF00D);
    expectWrite(5'd14, 32'hCAFEF00D);
    step();

    // Late half load: descriptor must be latched, inputs changed meanwhile
    applyStimulus(1'b1, T_M2R, 5'd9, 32'd0, 2'd1, 1'b0, 2'd2, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, T_NONE, 5'd3, 32'd0, 2'd0, 1'b1, 2'd1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("late_in_ready_low", {31'd0, in_ready}, 32'd0);
      checkOutput("late_busy_high", {31'd0, busy}, 32'd1);
      if (i < 2) step();
    end
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'hABCD0000;
    expectWrite(5'd9, 32'h0000ABCD);
    step();
    idle();
    checkOutput("late_in_ready_back", {31'd0, in_ready}, 32'd1);
    checkOutput("late_busy_low", {31'd0, busy}, 32'd0);

    // Misaligned word and half loads
    applyStimulus(1'b1, T_M2R, 5'd10, 32'd0, 2'd2, 1'b0, 2'd1, 1'b1, 32'h11223344);
    expectMisalign();
    step();
    applyStimulus(1'b1, T_M2R, 5'd11, 32'd0, 2'd1, 1'b0, 2'd3, 1'b1, 32'h11223344);
    expectMisalign();
    step();
    idle();
    step();
    checkOutput("misalign_pulse_end", {31'd0, misalign}, 32'd0);

    // Register 0 write suppressed; address/data still update
    applyStimulus(1'b1, T_R2R, 5'd0, 32'h12345678, 2'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    step();
    idle();
    checkOutput("reg0_enable", {31'd0, reg_write_enable}, 32'd0);
    checkOutput("reg0_addr", {27'd0, reg_write_addr}, 32'd0);
    checkOutput("reg0_data", reg_write_data, 32'h12345678);

    // NONE and R2M produce no write
    applyStimulus(1'b1, T_NONE, 5'd4, 32'h55555555, 2'd0, 1'b0, 2'd0, 1'b1, 32'h1);
    step();
    applyStimulus(1'b1, T_R2M, 5'd4, 32'h66666666, 2'd0, 1'b0, 2'd0, 1'b1, 32'h1);
    step();
    idle();
    step();
    checkOutput("none_r2m_data_hold", reg_write_data, 32'h12345678);

    // Flush wins over an R2R in IDLE
    applyStimulus(1'b1, T_R2R, 5'd6, 32'h77777777, 2'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    checkOutput("flush_idle_enable", {31'd0, reg_write_enable}, 32'd0);

    // Flush while waiting: later data ignored
    applyStimulus(1'b1, T_M2R, 5'd15, 32'd0, 2'd2, 1'b0, 2'd0, 1'b0, 32'd0);
    step();
    idle();
    checkOutput("flush_wait_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'h99999999;
    step();
    idle();
    checkOutput("flush_no_write", {31'd0, reg_write_enable}, 32'd0);

    // Reset in the middle of a late load
    applyStimulus(1'b1, T_R2R, 5'd21, 32'hA5A5A5A5, 2'd0, 1'b0, 2'd0, 1'b0, 32'd0);
    expectWrite(5'd21, 32'hA5A5A5A5);
    step();
    applyStimulus(1'b1, T_M2R, 5'd22, 32'd0, 2'd2, 1'b0, 2'd0, 1'b0, 32'd0);
    step();
    idle();
    checkOutput("rst_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'hBBBBBBBB;
    step();
    rst = 1'b0;
    idle();
    checkOutput("rst_mid_enable", {31'd0, reg_write_enable}, 32'd0);
    checkOutput("rst_mid_addr", {27'd0, reg_write_addr}, 32'd0);
    checkOutput("rst_mid_data", reg_write_data, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    mem_rdata_valid = 1'b1;
    step();
    idle();
    step();
    step();

    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
